ycbcr_block_sequencer: RTL and testbench
========================================

Name: ycbcr_block_sequencer

Overview:
- Controller that sequences the fixed-latency CSD RGB→YCbCr converter for one frame job.
- Host pulses start with a block count. The block accepts RGB pixels over a valid/ready stream and issues one pixel per cycle to the converter.
- It tracks pixels in flight and buffers the converter results in an output FIFO.
- It emits YCbCr samples with 8x8-block framing (64 pixels per block) to the downstream DCT stage, and pulses done when the job has fully drained.

Parameters:
- FIXED_POINT_LENGTH, 32, width of each Y/Cb/Cr fixed-point word.
- INPUT_WIDTH, 8, width of each R/G/B component.
- CONV_LATENCY, 2, converter pipeline latency in cycles (≥1).
- FIFO_DEPTH, 8, output FIFO entries (power of 2, ≥ CONV_LATENCY+1).
- BLK_CNT_W, 16, width of the block count.

Ports:
- clk, in, 1: single clock, rising edge.
- rst, in, 1: reset.
- start, in, 1: job start pulse; sampled only in IDLE.
- num_blocks, in, BLK_CNT_W: blocks in the job; captured on start.
- busy, out, 1: high in RUN or DRAIN.
- done, out, 1: one-cycle pulse at job end.
- pix_valid, in, 1: input pixel valid.
- pix_ready, out, 1: input pixel ready.
- r_in / g_in / b_in, in, INPUT_WIDTH each: pixel components.
- conv_r / conv_g / conv_b, out, INPUT_WIDTH each: registered operands to the converter.
- conv_y / conv_cb / conv_cr, in, FIXED_POINT_LENGTH each: converter results.
- out_valid, in... correction: out_valid, out, 1: output sample valid.
- out_ready, in, 1: downstream ready.
- y_out / cb_out / cr_out, out, FIXED_POINT_LENGTH each: FIFO head data.
- out_first, out, 1: head is pixel 0 of its block.
- out_last, out, 1: head is pixel 63 of its block.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high.
- Reset values:
  - State = IDLE.
  - busy, done, pix_ready, out_valid, out_first, out_last = 0.
  - conv_r/g/b = 0.
  - Valid pipe cleared, FIFO empty, all counters 0.
  - y/cb/cr_out = 0 when FIFO is empty.
- FSM states: IDLE, RUN, DRAIN.
  - IDLE→RUN: start=1 and num_blocks≠0. Captures total = num_blocks*64 and clears counters.
  - IDLE, start with num_blocks=0: done pulses the next cycle and the state stays IDLE.
  - RUN→DRAIN: on the cycle the last input pixel is accepted.
  - DRAIN→IDLE: valid pipe empty, FIFO empty, and the last output handshake completed. done=1 for exactly that one cycle.
  - start is ignored while busy.
- Input issue and credit rule:
  - credit = FIFO_DEPTH − fifo_count − inflight, where inflight is the popcount of the valid pipe.
  - pix_ready = (state==RUN) && (credit>0). It is combinational from registered state only and does not depend on pix_valid.
  - Accept = pix_valid && pix_ready. On accept, conv_r/g/b are registered and a 1 enters the CONV_LATENCY-deep valid shift register.
  - When no pixel is accepted, conv_r/g/b hold their value and a 0 enters the valid pipe.
- Capture: when the valid pipe tail is 1, conv_y/cb/cr are written to the FIFO in that cycle.
  - Total latency is 1 (operand register) + CONV_LATENCY.
  - Input accept at cycle t gives FIFO write at t+CONV_LATENCY and out_valid at t+CONV_LATENCY+1.
- FIFO behaviour:
  - The credit rule guarantees the FIFO never overflows. Any write while full is a design error; the bench asserts on it.
  - Simultaneous push and pop in the same cycle is legal at any fill level, including full and empty.
- Output:
  - out_valid = FIFO not empty.
  - Output data and flags hold stable while out_valid && !out_ready.
- Framing:
  - The output pixel counter runs 0..63 and advances on each output handshake, wrapping 63→0.
  - out_first = (cnt==0). out_last = (cnt==63).
  - The block counter increments on the out_last handshake. Job end = block counter reaches num_blocks.
- Throughput: sustains 1 pixel/cycle with out_ready held at 1. Back-pressure stalls pix_ready within at most one cycle once credit reaches 0.
- Reset mid-job: asynchronously abandons everything. FIFO and pipe are flushed, done is not pulsed, and the state returns to IDLE.

Decomposition:
- Package ycbcr_pkg holds:
  - BLOCK_PIXELS=64.
  - FSM state encoding: IDLE, RUN, DRAIN.
  - Width constants shared with the converter: FIXED_POINT_LENGTH, INPUT_WIDTH.
- One sub-module, ycbcr_result_fifo:
  - Synchronous FIFO, 3×FIXED_POINT_LENGTH wide, FIFO_DEPTH deep.
  - Provides count, full, and empty outputs.
  - Async active-high reset.
- The converter itself is not instantiated here; the wrapper top connects it.

Test Plan:
- Black pixel, one block, out_ready=1:
  - Stimulus: num_blocks=1, 64 pixels (0,0,0) sent back-to-back; behavioural converter model returns Y=0, Cb=Cr=128<<16.
  - Required: 64 outputs with Y=0x0 and Cb=Cr=0x00800000; out_first on output 0 and out_last on output 63; first out_valid 3 cycles after the first accept.
  - Required: done pulses once, 1 cycle after the final handshake.
- Full throughput:
  - Stimulus: num_blocks=2, out_ready=1 throughout, distinct pixel values e.g. 255/0/0 then 0/255/0.
  - Required: pix_ready never drops, 128 outputs in order with values matching the model, and the job completes in 128+3 cycles.
- Back-pressure:
  - Stimulus: out_ready=0 for 20 cycles mid-block.
  - Required: pix_ready falls once FIFO_DEPTH (8) samples are stored or in flight; no sample is lost or duplicated, and ordering is preserved after release.
- Zero blocks:
  - Stimulus: start with num_blocks=0.
  - Required: done pulses next cycle, busy stays 0, pix_ready stays 0.
- Reset mid-job:
  - Stimulus: assert rst after 30 pixels of a 2-block job.
  - Required: outputs go to reset values immediately with no done pulse; a following num_blocks=1 job completes normally with exactly 64 outputs.
- Start while busy:
  - Stimulus: a second start pulse in RUN.
  - Required: it is ignored and the output count equals the original num_blocks*64.

Source files
------------

// File: rtl/ycbcr_pkg.sv
// Shared constants and sequencer state type for the YCbCr block path.
package ycbcr_pkg;
  localparam int FIXED_POINT_LENGTH = 32;
  localparam int INPUT_WIDTH        = 8;
  localparam int BLOCK_PIXELS       = 64;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } seq_state_t;
endpackage

// File: rtl/ycbcr_result_fifo.sv
// Synchronous result FIFO for converter outputs; head data reads as zero when empty.
module ycbcr_result_fifo #(
  parameter int WIDTH = 3 * ycbcr_pkg::FIXED_POINT_LENGTH,
  parameter int DEPTH = 8,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic [AW:0]      count,
  output logic             full,
  output logic             empty
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             push_ok, pop_ok;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign pop_ok  = pop && !empty;
  // A push into a full FIFO is fine when the same cycle frees the head slot.
  assign push_ok = push && (!full || pop_ok);
  assign rdata   = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/ycbcr_block_sequencer.sv
// Sequences one frame job through the fixed-latency RGB->YCbCr converter and
// frames the buffered results into 64-pixel blocks for the DCT stage.
module ycbcr_block_sequencer #(
  parameter int FIXED_POINT_LENGTH = ycbcr_pkg::FIXED_POINT_LENGTH,
  parameter int INPUT_WIDTH        = ycbcr_pkg::INPUT_WIDTH,
  parameter int CONV_LATENCY       = 2,
  parameter int FIFO_DEPTH         = 8,
  parameter int BLK_CNT_W          = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [BLK_CNT_W-1:0]          num_blocks,
  output logic                          busy,
  output logic                          done,
  input  logic                          pix_valid,
  output logic                          pix_ready,
  input  logic [INPUT_WIDTH-1:0]        r_in,
  input  logic [INPUT_WIDTH-1:0]        g_in,
  input  logic [INPUT_WIDTH-1:0]        b_in,
  output logic [INPUT_WIDTH-1:0]        conv_r,
  output logic [INPUT_WIDTH-1:0]        conv_g,
  output logic [INPUT_WIDTH-1:0]        conv_b,
  input  logic [FIXED_POINT_LENGTH-1:0] conv_y,
  input  logic [FIXED_POINT_LENGTH-1:0] conv_cb,
  input  logic [FIXED_POINT_LENGTH-1:0] conv_cr,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [FIXED_POINT_LENGTH-1:0] y_out,
  output logic [FIXED_POINT_LENGTH-1:0] cb_out,
  output logic [FIXED_POINT_LENGTH-1:0] cr_out,
  output logic                          out_first,
  output logic                          out_last
);
  import ycbcr_pkg::*;

  localparam int PIX_W = $clog2(BLOCK_PIXELS);
  localparam int TOT_W = BLK_CNT_W + PIX_W;
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int DW    = 3 * FIXED_POINT_LENGTH;

  seq_state_t state, state_nxt;
  logic                    done_nxt, job_start;
  logic [BLK_CNT_W-1:0]    nblk_q, blk_cnt;
  logic [TOT_W-1:0]        total_q, in_cnt;
  logic [PIX_W-1:0]        pix_cnt;
  logic [CONV_LATENCY-1:0] vpipe, vpipe_nxt;
  logic [CNT_W-1:0]        inflight, fifo_count;
  logic                    fifo_full, fifo_empty, fifo_push, fifo_pop;
  logic [DW-1:0]           fifo_rdata;
  logic                    credit_ok, accept, last_in, pix_last, final_hs;

  always_comb begin
    inflight = '0;
    for (int unsigned i = 0; i < CONV_LATENCY; i++)
      inflight = inflight + CNT_W'(vpipe[i]);
  end

  // Everything already in the pipe is owed a FIFO slot, so it counts against credit.
  assign credit_ok = !fifo_full &&
                     (({1'b0, fifo_count} + {1'b0, inflight}) < (CNT_W+1)'(FIFO_DEPTH));
  assign pix_ready = (state == RUN) && credit_ok;
  assign accept    = pix_valid && pix_ready;
  assign last_in   = accept && (in_cnt == total_q - TOT_W'(1));

  assign fifo_push = vpipe[CONV_LATENCY-1];
  assign fifo_pop  = out_valid && out_ready;
  assign pix_last  = (pix_cnt == PIX_W'(BLOCK_PIXELS - 1));
  assign final_hs  = fifo_pop && pix_last && (blk_cnt == nblk_q - BLK_CNT_W'(1));

  always_comb begin
    vpipe_nxt    = vpipe << 1;
    vpipe_nxt[0] = accept;
  end

  // The last handshake implies pipe and FIFO are drained after this edge,
  // so leaving DRAIN on that handshake puts done one cycle after it.
  always_comb begin
    state_nxt = state;
    done_nxt  = 1'b0;
    job_start = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          if (num_blocks != '0) begin
            state_nxt = RUN;
            job_start = 1'b1;
          end else begin
            done_nxt = 1'b1;
          end
        end
      end
      RUN:   if (last_in) state_nxt = DRAIN;
      DRAIN: begin
        if (final_hs) begin
          state_nxt = IDLE;
          done_nxt  = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      done    <= 1'b0;
      nblk_q  <= '0;
      total_q <= '0;
      in_cnt  <= '0;
      pix_cnt <= '0;
      blk_cnt <= '0;
      vpipe   <= '0;
      conv_r  <= '0;
      conv_g  <= '0;
      conv_b  <= '0;
    end else begin
      state <= state_nxt;
      done  <= done_nxt;
      vpipe <= vpipe_nxt;
      if (job_start) begin
        nblk_q  <= num_blocks;
        total_q <= {num_blocks, {PIX_W{1'b0}}};
        in_cnt  <= '0;
        pix_cnt <= '0;
        blk_cnt <= '0;
      end else begin
        if (accept) in_cnt <= in_cnt + 1'b1;
        if (fifo_pop) begin
          pix_cnt <= pix_cnt + 1'b1;
          if (pix_last) blk_cnt <= blk_cnt + 1'b1;
        end
      end
      if (accept) begin
        conv_r <= r_in;
        conv_g <= g_in;
        conv_b <= b_in;
      end
    end
  end

  ycbcr_result_fifo #(
    .WIDTH (DW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .wdata ({conv_y, conv_cb, conv_cr}),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign busy      = (state != IDLE);
  assign out_valid = !fifo_empty;
  assign y_out     = fifo_rdata[DW-1 -: FIXED_POINT_LENGTH];
  assign cb_out    = fifo_rdata[2*FIXED_POINT_LENGTH-1 -: FIXED_POINT_LENGTH];
  assign cr_out    = fifo_rdata[FIXED_POINT_LENGTH-1:0];
  assign out_first = !fifo_empty && (pix_cnt == '0);
  assign out_last  = !fifo_empty && pix_last;
endmodule

// File: tb/tb_ycbcr_block_sequencer.sv
// Bench for ycbcr_block_sequencer: queue-based job model plus a behavioural converter.
module tb_ycbcr_block_sequencer;
  logic        clk = 1'b0, rst = 1'b1;
  logic        start = 1'b0, pix_valid = 1'b0, out_ready = 1'b1;
  logic [15:0] num_blocks = '0;
  logic [7:0]  r_in = '0, g_in = '0, b_in = '0;
  logic [7:0]  conv_r, conv_g, conv_b;
  logic [31:0] conv_y = '0, conv_cb = '0, conv_cr = '0;
  logic [31:0] y_out, cb_out, cr_out;
  logic        busy, done, pix_ready, out_valid, out_first, out_last;

  int tests = 0, fails = 0;

  ycbcr_block_sequencer #(
    .FIXED_POINT_LENGTH (32),
    .INPUT_WIDTH        (8),
    .CONV_LATENCY       (2),
    .FIFO_DEPTH         (8),
    .BLK_CNT_W          (16)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .num_blocks(num_blocks),
    .busy(busy), .done(done), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .r_in(r_in), .g_in(g_in), .b_in(b_in),
    .conv_r(conv_r), .conv_g(conv_g), .conv_b(conv_b),
    .conv_y(conv_y), .conv_cb(conv_cb), .conv_cr(conv_cr),
    .out_valid(out_valid), .out_ready(out_ready),
    .y_out(y_out), .cb_out(cb_out), .cr_out(cr_out),
    .out_first(out_first), .out_last(out_last)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [95:0] conv_f(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
    int ri, gi, bi, y, cb, cr;
    ri = int'(r); gi = int'(g); bi = int'(b);
    y  = (77 * ri + 150 * gi + 29 * bi) * 256;
    cb = (-43 * ri - 85 * gi + 128 * bi) * 256 + (128 << 16);
    cr = (128 * ri - 107 * gi - 21 * bi) * 256 + (128 << 16);
    return {32'(y), 32'(cb), 32'(cr)};
  endfunction

  // Converter stand-in: one register after the operand register gives latency 2.
  always @(posedge clk) {conv_y, conv_cb, conv_cr} <= conv_f(conv_r, conv_g, conv_b);

  // Job model: every accepted pixel owes one output, visible 3 cycles after accept.
  typedef struct { logic [95:0] d; int rdy; } ent_t;
  ent_t q[$];
  bit m_busy = 0, m_done = 0;
  int m_in_left = 0, m_out_left = 0, m_idx = 0, cyc = 0;

  function automatic bit exp_ready();
    return m_busy && (m_in_left > 0) && (q.size() < 8);
  endfunction
  function automatic bit exp_valid();
    return (q.size() > 0) && (q[0].rdy <= cyc);
  endfunction

  int first_acc = -1, first_ov = -1, last_hs = -1, done_cyc = -1, done_cnt = 0;
  int out_cnt = 0, in_acc = 0, max_out = 0;
  logic [31:0] first_y = '0, first_cb = '0;
  bit stall_seen = 0;

  always @(posedge clk or posedge rst) begin
    bit acc, hs, was_busy;
    if (rst) begin
      q.delete();
      m_busy = 0; m_done = 0; m_in_left = 0; m_out_left = 0; m_idx = 0;
    end else begin
      acc = pix_valid && exp_ready();
      hs  = out_ready && exp_valid();
      was_busy = m_busy;
      m_done = 0;
      if (hs) begin
        void'(q.pop_front());
        m_idx++;
        m_out_left--;
        if (m_out_left == 0) begin m_busy = 0; m_done = 1; end
      end
      if (acc) begin
        q.push_back('{conv_f(r_in, g_in, b_in), cyc + 3});
        m_in_left--;
        if (first_acc < 0) first_acc = cyc;
      end
      if (!was_busy && start) begin
        if (num_blocks == 0) m_done = 1;
        else begin
          m_busy = 1; m_in_left = int'(num_blocks) * 64;
          m_out_left = m_in_left; m_idx = 0;
        end
      end
    end
    cyc++;
  end

  always @(negedge clk) begin
    chk("busy", busy, m_busy);
    chk("done", done, m_done);
    chk("pix_ready", pix_ready, exp_ready());
    chk("out_valid", out_valid, exp_valid());
    if (exp_valid()) begin
      chk("y_out", y_out, q[0].d[95:64]);
      chk("cb_out", cb_out, q[0].d[63:32]);
      chk("cr_out", cr_out, q[0].d[31:0]);
      chk("out_first", out_first, (m_idx % 64) == 0);
      chk("out_last", out_last, (m_idx % 64) == 63);
    end else begin
      chk("empty_data", {y_out, cb_out}, 64'h0);
      chk("empty_flags", {out_first, out_last}, 2'b00);
    end
    chk("fifo_overflow", dut.fifo_push && dut.fifo_full && !dut.fifo_pop, 1'b0);
    if (out_valid && first_ov < 0) begin first_ov = cyc; first_y = y_out; first_cb = cb_out; end
    if (pix_valid && pix_ready) in_acc++;
    if (out_valid && out_ready) begin out_cnt++; last_hs = cyc; end
    if (in_acc - out_cnt > max_out) max_out = in_acc - out_cnt;
    if (busy && !pix_ready && m_in_left > 0) stall_seen = 1;
    if (done) begin done_cnt++; done_cyc = cyc; end
  end

  task automatic clear_marks();
    first_acc = -1; first_ov = -1; last_hs = -1; done_cyc = -1; done_cnt = 0;
    out_cnt = 0; in_acc = 0; max_out = 0; stall_seen = 0;
  endtask

  task automatic do_start(input int n);
    start = 1'b1; num_blocks = 16'(n);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  function automatic logic [23:0] pix(input int k, input int mode);
    logic [7:0] a, b, c;
    case (mode)
      0: begin a = 8'd0; b = 8'd0; c = 8'd0; end
      1: if (k < 64) begin a = 8'd255; b = 8'd0; c = 8'd0; end
         else        begin a = 8'd0; b = 8'd255; c = 8'd0; end
      default: begin a = 8'(k * 7); b = 8'(k * 13 + 5); c = 8'(255 - k); end
    endcase
    return {a, b, c};
  endfunction

  // Feeds n pixels; optionally pulses start again at pixel restart_at.
  task automatic feed(input int n, input int mode, input int restart_at, output int iters);
    int k = 0;
    bit hs;
    iters = 0;
    while (k < n && iters < 2000) begin
      pix_valid = 1'b1;
      {r_in, g_in, b_in} = pix(k, mode);
      if (k == restart_at) begin start = 1'b1; num_blocks = 16'd5; end
      @(negedge clk);
      hs = pix_ready;
      @(posedge clk); #1;
      start = 1'b0;
      iters++;
      if (hs) k++;
    end
    pix_valid = 1'b0;
    if (k < n) chk("feed_timeout", k, n);
  endtask

  task automatic wait_done(input int limit);
    int n = 0;
    while (done_cnt == 0 && n < limit) begin @(posedge clk); #1; n++; end
    chk("done_seen", done_cnt != 0, 1'b1);
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    int it;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", busy, 1'b0);
    chk("rst_ready", pix_ready, 1'b0);
    chk("rst_conv", {conv_r, conv_g, conv_b}, 24'h0);
    chk("rst_out", {out_valid, done, y_out}, 34'h0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Black pixels, one block
    clear_marks();
    do_start(1);
    feed(64, 0, -1, it);
    wait_done(200);
    chk("blk_out_cnt", out_cnt, 64);
    chk("blk_first_y", first_y, 32'h0);
    chk("blk_first_cb", first_cb, 32'h0080_0000);
    chk("blk_latency", first_ov - first_acc, 3);
    chk("blk_done_cnt", done_cnt, 1);
    chk("blk_done_lat", done_cyc - last_hs, 1);

    // Full throughput, two blocks
    clear_marks();
    do_start(2);
    feed(128, 1, -1, it);
    wait_done(200);
    chk("thr_iters", it, 128);
    chk("thr_stall", stall_seen, 1'b0);
    chk("thr_out_cnt", out_cnt, 128);
    chk("thr_first_y", first_y, 32'h004C_B300);
    chk("thr_job_cycles", done_cyc - first_acc, 131);

    // Back-pressure mid-block
    clear_marks();
    do_start(1);
    fork
      feed(64, 2, -1, it);
      begin
        repeat (20) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (20) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    wait_done(200);
    chk("bp_stall_seen", stall_seen, 1'b1);
    chk("bp_max_outstanding", max_out, 8);
    chk("bp_out_cnt", out_cnt, 64);
    chk("bp_done_cnt", done_cnt, 1);

    // Zero blocks
    clear_marks();
    do_start(0);
    @(negedge clk);
    chk("zero_done", done, 1'b1);
    chk("zero_busy", busy, 1'b0);
    chk("zero_ready", pix_ready, 1'b0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("zero_done_once", done, 1'b0);
    @(posedge clk); #1;

    // Reset mid-job, then a clean one-block job
    clear_marks();
    do_start(2);
    feed(30, 2, -1, it);
    rst = 1'b1;
    #1;
    chk("mrst_busy", busy, 1'b0);
    chk("mrst_valid", {out_valid, out_first, out_last}, 3'b000);
    chk("mrst_data", {y_out, cb_out}, 64'h0);
    chk("mrst_conv", {conv_r, conv_g, conv_b}, 24'h0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("mrst_no_done", done_cnt, 0);
    clear_marks();
    do_start(1);
    feed(64, 1, -1, it);
    wait_done(200);
    chk("mrst_out_cnt", out_cnt, 64);

    // Start while busy is ignored
    clear_marks();
    do_start(1);
    feed(64, 2, 10, it);
    wait_done(200);
    chk("sib_out_cnt", out_cnt, 64);
    chk("sib_done_cnt", done_cnt, 1);
    repeat (5) @(posedge clk);
    #1;
    chk("sib_idle", busy, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got timeout expected finish");
    $fatal(1, "timeout");
  end
endmodule
